adc_calc_sched: RTL and testbench
=================================

Name: adc_calc_sched

Overview:
- Time-multiplexed gain/offset scheduler for the ADC calculation path.
- On each ADC frame strobe, it snapshots all raw channel samples together with their factor/offset registers (as programmed over AXI4-Lite).
- It then sequences the channels one per cycle through a single shared 3-stage multiply-add pipeline and emits a tagged result stream.
- It sits between the ADC capture logic and the downstream consumers (control loop, telemetry).

Parameters:
- CH_NUM, 10, number of ADC channels sequenced per frame (1..16).
- RAW_W, 16, width of one signed raw ADC sample.
- FRAC_W, 16, fractional bits of the signed Q(32-FRAC_W).FRAC_W factor.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_adc_valid  in  1  one-cycle strobe: i_adc_data holds a complete new frame.
- i_adc_data  in  CH_NUM*RAW_W  raw signed samples, channel 0 in the LSBs.
- i_factor  in  CH_NUM*32  signed gain factors, channel 0 in the LSBs.
- i_offset  in  CH_NUM*32  signed offsets (result LSB units), channel 0 in the LSBs.
- i_ovr_clr  in  1  clears o_overrun.
- o_calc_data  out  32  signed calibrated result.
- o_calc_ch  out  4  channel index of o_calc_data.
- o_calc_valid  out  1  result strobe, one cycle per channel.
- o_frame_done  out  1  one-cycle pulse after the last channel of a frame.
- o_busy  out  1  frame in progress.
- o_overrun  out  1  sticky: a strobe arrived while busy.
- o_sat  out  1  qualifies o_calc_valid: the result was clamped.

Behaviour:
- Reset is asynchronous and active-low: i_clk single clock domain, i_rst_n asynchronous active-low.
  - All outputs reset to 0.
  - FSM resets to IDLE, channel counter to 0, pipeline valid bits to 0.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE: on i_adc_valid at edge E0, register snapshots of i_adc_data, i_factor and i_offset; ch_cnt=0; go to ISSUE.
  - ISSUE: each cycle, issue channel ch_cnt into pipeline stage 1 (operands from the snapshot) and increment ch_cnt. After issuing CH_NUM-1, go to DRAIN.
  - DRAIN: wait until the stage-3 valid of channel CH_NUM-1 has been output, then go to IDLE with o_frame_done=1 for one cycle.
- Snapshot rule: AXI writes to factor/offset during a frame have no effect until the next frame. All channels of a frame use a coherent register set.
- Pipeline:
  - S1: register operands.
  - S2: 48-bit signed product raw*factor.
  - S3: arithmetic shift right by FRAC_W, sign-extend to 33 bits, add sign-extended offset, resolve to 32 bits, register output.
- Latency:
  - Channel k: o_calc_valid=1 with o_calc_ch=k in the cycle following edge E3+k.
  - o_frame_done is asserted in the cycle following edge E3+CH_NUM.
  - o_busy=1 from after E0 up to and including the o_frame_done cycle.
- Channel order is strictly ascending 0..CH_NUM-1, with no gaps in o_calc_valid within a frame.
- o_calc_data and o_calc_ch hold their last values when o_calc_valid=0.
- Overrun: i_adc_valid while o_busy=1 (including the o_frame_done cycle) is ignored and sets o_overrun. A strobe on the first cycle after o_frame_done is accepted normally.
- i_ovr_clr clears o_overrun. If set and clear occur in the same cycle, set wins.
- Reset mid-frame aborts immediately: no further valids, no o_frame_done; o_overrun is cleared.
- CH_NUM=1: ISSUE lasts one cycle; the timing above still holds.

Optional Feature:
- Macro: CALC_SAT_EN.
- Defined: the 33-bit sum is clamped to 0x7FFFFFFF / 0x80000000, and o_sat=1 with that result's o_calc_valid.
- Undefined: the result is the low 32 bits of the sum (two's-complement wrap), and o_sat is tied to 0.

Test Plan:
- Identity: ch0 raw 0x1234, factor 0x00010000, offset 0, strobe -> o_calc_ch=0, o_calc_data=0x00001234, valid after E3; o_frame_done after E3+10.
- Signed scale plus offset: ch3 raw 0xFFFE (-2), factor 0x00018000 (1.5), offset 5 -> o_calc_ch=3, o_calc_data=0x00000002, valid after E6.
- Saturation: ch9 raw 0x7FFF, factor 0x7FFFFFFF, offset 0x7FFFFFFF -> with CALC_SAT_EN: 0x7FFFFFFF and o_sat=1; without: 0xBFFF7FFE and o_sat=0.
- Snapshot coherence: change ch5 factor from 0x00010000 to 0x00020000 two cycles after the strobe (raw 100) -> that frame gives 100; the next frame gives 200.
- Overrun: second strobe 4 cycles after the first -> ignored (exactly 10 valids, one frame_done), o_overrun=1 until an i_ovr_clr pulse; a strobe on the cycle after frame_done starts a new frame with no overrun.
- Reset mid-frame: assert i_rst_n low after channel 4 output -> all outputs 0 immediately; after release, a new strobe produces a complete frame 0..9.

Source files
------------

// File: rtl/adc_calc_sched.sv
// adc_calc_sched: frame-based gain/offset scheduler for the ADC calculation path.
// A frame strobe snapshots every raw sample with its factor/offset; the channels
// are then issued one per cycle through a shared 3-stage multiply-add pipeline.
// Optional build macro CALC_SAT_EN: clamp results to the signed 32-bit range and
// flag clamped results on o_sat (otherwise results wrap and o_sat stays 0).
`timescale 1ns/1ps

module adc_calc_sched #(
  parameter int CH_NUM = 10,
  parameter int RAW_W  = 16,
  parameter int FRAC_W = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_adc_valid,
  input  logic [CH_NUM*RAW_W-1:0] i_adc_data,
  input  logic [CH_NUM*32-1:0]    i_factor,
  input  logic [CH_NUM*32-1:0]    i_offset,
  input  logic                    i_ovr_clr,
  output logic [31:0]             o_calc_data,
  output logic [3:0]              o_calc_ch,
  output logic                    o_calc_valid,
  output logic                    o_frame_done,
  output logic                    o_busy,
  output logic                    o_overrun,
  output logic                    o_sat
);

  localparam int         PROD_W  = RAW_W + 32;
  localparam logic [3:0] LAST_CH = 4'(CH_NUM - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                    state_r;
  logic [3:0]                ch_cnt_r;
  logic [CH_NUM*RAW_W-1:0]   snap_raw_r;
  logic [CH_NUM*32-1:0]      snap_fac_r;
  logic [CH_NUM*32-1:0]      snap_off_r;

  // Stage 1: operands of the channel being issued
  logic signed [RAW_W-1:0]   s1_raw_r;
  logic signed [31:0]        s1_fac_r;
  logic signed [31:0]        s1_off_r;
  logic [3:0]                s1_ch_r;
  logic                      s1_vld_r;

  // Stage 2: full-precision product
  logic signed [PROD_W-1:0]  s2_prod_r;
  logic signed [31:0]        s2_off_r;
  logic [3:0]                s2_ch_r;
  logic                      s2_vld_r;

  logic signed [PROD_W-1:0]  raw_ext_s;
  logic signed [PROD_W-1:0]  fac_ext_s;
  logic [31:0]               result_s;
  logic                      sat_s;

  // Sign-extend both operands so the truncated product keeps the exact low bits
  assign raw_ext_s = PROD_W'(s1_raw_r);
  assign fac_ext_s = PROD_W'(s1_fac_r);

`ifdef CALC_SAT_EN
  logic [32:0] sum_s;
  logic        ovf_s;
  // One guard bit above the 32-bit result exposes overflow of the offset add
  assign sum_s    = 33'(s2_prod_r >>> FRAC_W) + {s2_off_r[31], s2_off_r};
  assign ovf_s    = sum_s[32] ^ sum_s[31];
  assign result_s = ovf_s ? (sum_s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF) : sum_s[31:0];
  assign sat_s    = ovf_s;
`else
  logic [31:0] sum_s;
  // Two's-complement wrap: only the low 32 bits of the sum are kept
  assign sum_s    = 32'(s2_prod_r >>> FRAC_W) + s2_off_r;
  assign result_s = sum_s;
  assign sat_s    = 1'b0;
`endif

  // Frame sequencer: snapshot, channel issue, drain, busy/done/overrun flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= IDLE;
      ch_cnt_r     <= 4'd0;
      snap_raw_r   <= '0;
      snap_fac_r   <= '0;
      snap_off_r   <= '0;
      s1_raw_r     <= '0;
      s1_fac_r     <= 32'sd0;
      s1_off_r     <= 32'sd0;
      s1_ch_r      <= 4'd0;
      s1_vld_r     <= 1'b0;
      o_frame_done <= 1'b0;
      o_busy       <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      s1_vld_r     <= 1'b0;
      o_frame_done <= 1'b0;

      // A strobe while busy (done cycle included) is dropped; setting beats clearing
      if (i_adc_valid && o_busy) begin
        o_overrun <= 1'b1;
      end else if (i_ovr_clr) begin
        o_overrun <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          if (i_adc_valid && !o_busy) begin
            snap_raw_r <= i_adc_data;
            snap_fac_r <= i_factor;
            snap_off_r <= i_offset;
            ch_cnt_r   <= 4'd0;
            o_busy     <= 1'b1;
            state_r    <= ISSUE;
          end else begin
            o_busy     <= 1'b0;
          end
        end
        ISSUE: begin
          s1_raw_r <= snap_raw_r[int'(ch_cnt_r)*RAW_W +: RAW_W];
          s1_fac_r <= snap_fac_r[int'(ch_cnt_r)*32 +: 32];
          s1_off_r <= snap_off_r[int'(ch_cnt_r)*32 +: 32];
          s1_ch_r  <= ch_cnt_r;
          s1_vld_r <= 1'b1;
          ch_cnt_r <= ch_cnt_r + 4'd1;
          if (ch_cnt_r == LAST_CH) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          // Finish once the last channel's result is on the output
          if (o_calc_valid && (o_calc_ch == LAST_CH)) begin
            o_frame_done <= 1'b1;
            state_r      <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Stages 2 and 3: multiply, then shift, offset add, resolve and register the result
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_prod_r    <= '0;
      s2_off_r     <= 32'sd0;
      s2_ch_r      <= 4'd0;
      s2_vld_r     <= 1'b0;
      o_calc_data  <= 32'd0;
      o_calc_ch    <= 4'd0;
      o_calc_valid <= 1'b0;
      o_sat        <= 1'b0;
    end else begin
      s2_vld_r     <= s1_vld_r;
      o_calc_valid <= s2_vld_r;
      o_sat        <= s2_vld_r & sat_s;
      if (s1_vld_r) begin
        s2_prod_r <= raw_ext_s * fac_ext_s;
        s2_off_r  <= s1_off_r;
        s2_ch_r   <= s1_ch_r;
      end
      // Data and channel tag hold their last values between results
      if (s2_vld_r) begin
        o_calc_data <= result_s;
        o_calc_ch   <= s2_ch_r;
      end
    end
  end

endmodule

// File: tb/tb_adc_calc_sched.sv
// Self-checking bench for adc_calc_sched: randomized frames compared cycle by
// cycle against an arithmetic reference model, plus the directed scenarios.
`timescale 1ns/1ps

module tb_adc_calc_sched;

  localparam int CH = 10;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic              i_adc_valid;
  logic [CH*16-1:0]  i_adc_data;
  logic [CH*32-1:0]  i_factor;
  logic [CH*32-1:0]  i_offset;
  logic              i_ovr_clr;
  logic [31:0]       o_calc_data;
  logic [3:0]        o_calc_ch;
  logic              o_calc_valid;
  logic              o_frame_done;
  logic              o_busy;
  logic              o_overrun;
  logic              o_sat;

  logic signed [15:0] raw_a [CH];
  logic signed [31:0] fac_a [CH];
  logic signed [31:0] off_a [CH];
  logic [31:0]        got_data [CH];
  logic               exp_ovr;
  int                 n_chk = 0;
  int                 n_bad = 0;

  always #5 i_clk = ~i_clk;

  adc_calc_sched #(.CH_NUM(CH), .RAW_W(16), .FRAC_W(16)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_adc_valid  (i_adc_valid),
    .i_adc_data   (i_adc_data),
    .i_factor     (i_factor),
    .i_offset     (i_offset),
    .i_ovr_clr    (i_ovr_clr),
    .o_calc_data  (o_calc_data),
    .o_calc_ch    (o_calc_ch),
    .o_calc_valid (o_calc_valid),
    .o_frame_done (o_frame_done),
    .o_busy       (o_busy),
    .o_overrun    (o_overrun),
    .o_sat        (o_sat)
  );

  // Pack the per-channel register arrays onto the wide input buses
  always_comb begin
    i_adc_data = '0;
    i_factor   = '0;
    i_offset   = '0;
    for (int i = 0; i < CH; i++) begin
      i_adc_data[i*16 +: 16] = raw_a[i];
      i_factor[i*32 +: 32]   = fac_a[i];
      i_offset[i*32 +: 32]   = off_a[i];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: real-valued scale then offset, resolved to 32 bits; {sat, data}
  function automatic logic [32:0] model(input logic signed [15:0] r,
                                        input logic signed [31:0] f,
                                        input logic signed [31:0] o);
    longint p;
    longint s;
    p = longint'(r) * longint'(f);
    s = (p >>> 16) + longint'(o);
`ifdef CALC_SAT_EN
    if (s > 64'sd2147483647) return {1'b1, 32'h7FFF_FFFF};
    if (s < -64'sd2147483648) return {1'b1, 32'h8000_0000};
    return {1'b0, s[31:0]};
`else
    return {1'b0, s[31:0]};
`endif
  endfunction

  task automatic randomize_regs();
    for (int i = 0; i < CH; i++) begin
      raw_a[i] = 16'($urandom);
      fac_a[i] = $signed(32'($urandom)) >>> $urandom_range(0, 14);
      off_a[i] = $signed(32'($urandom)) >>> $urandom_range(0, 24);
    end
  endtask

  // Runs one frame starting at a negedge; *_at give the cycle index t (t=0 is
  // the cycle after the accepting edge) of an extra strobe, a factor change,
  // or an asynchronous reset; -1 disables each.
  task automatic do_frame(input int ovr_at, input bit clr_with, input int chg_at, input int rst_at);
    logic signed [15:0] e_raw [CH];
    logic signed [31:0] e_fac [CH];
    logic signed [31:0] e_off [CH];
    logic [32:0]        m;
    logic               exp_v;
    for (int i = 0; i < CH; i++) begin
      e_raw[i] = raw_a[i];
      e_fac[i] = fac_a[i];
      e_off[i] = off_a[i];
    end
    i_adc_valid = 1'b1;
    @(posedge i_clk);
    for (int t = 0; t <= CH + 4; t++) begin
      @(negedge i_clk);
      if (ovr_at >= 0 && t == ovr_at + 1) exp_ovr = 1'b1;
      exp_v = (t >= 3) && (t <= CH + 2);
      chk("valid", o_calc_valid, exp_v);
      if (exp_v) begin
        m = model(e_raw[t-3], e_fac[t-3], e_off[t-3]);
        chk("ch", o_calc_ch, t - 3);
        chk("data", o_calc_data, m[31:0]);
        chk("sat", o_sat, m[32]);
        got_data[t-3] = o_calc_data;
      end
      chk("done", o_frame_done, t == CH + 3);
      chk("busy", o_busy, t <= CH + 3);
      chk("ovr", o_overrun, exp_ovr);
      if (t == CH + 4) begin
        m = model(e_raw[CH-1], e_fac[CH-1], e_off[CH-1]);
        chk("hold_ch", o_calc_ch, CH - 1);
        chk("hold_data", o_calc_data, m[31:0]);
      end
      i_adc_valid = 1'b0;
      i_ovr_clr   = 1'b0;
      if (t == ovr_at) begin
        i_adc_valid = 1'b1;
        if (clr_with) i_ovr_clr = 1'b1;
      end
      if (t == chg_at) fac_a[5] = fac_a[5] <<< 1;
      if (t == rst_at) begin
        i_rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", o_calc_valid, 1'b0);
        chk("rst_mid_data", o_calc_data, 32'd0);
        chk("rst_mid_ch", o_calc_ch, 4'd0);
        chk("rst_mid_busy", o_busy, 1'b0);
        chk("rst_mid_ovr", o_overrun, 1'b0);
        exp_ovr = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge i_clk);
          if (k == 1) i_rst_n = 1'b1;
          chk("rst_quiet_valid", o_calc_valid, 1'b0);
          chk("rst_quiet_done", o_frame_done, 1'b0);
          chk("rst_quiet_busy", o_busy, 1'b0);
        end
        return;
      end
    end
  endtask

  task automatic clear_overrun();
    @(negedge i_clk);
    chk("ovr_sticky", o_overrun, 1'b1);
    i_ovr_clr = 1'b1;
    @(negedge i_clk);
    i_ovr_clr = 1'b0;
    chk("ovr_cleared", o_overrun, 1'b0);
    exp_ovr = 1'b0;
  endtask

  initial begin
    i_rst_n     = 1'b0;
    i_adc_valid = 1'b0;
    i_ovr_clr   = 1'b0;
    exp_ovr     = 1'b0;
    randomize_regs();
    raw_a[0] = 16'sh1234; fac_a[0] = 32'sh0001_0000; off_a[0] = 32'sd0;
    raw_a[3] = -16'sd2;   fac_a[3] = 32'sh0001_8000; off_a[3] = 32'sd5;
    raw_a[5] = 16'sd100;  fac_a[5] = 32'sh0001_0000; off_a[5] = 32'sd0;
    raw_a[9] = 16'sh7FFF; fac_a[9] = 32'sh7FFF_FFFF; off_a[9] = 32'sh7FFF_FFFF;

    repeat (3) @(negedge i_clk);
    chk("rst_valid", o_calc_valid, 1'b0);
    chk("rst_data", o_calc_data, 32'd0);
    chk("rst_ch", o_calc_ch, 4'd0);
    chk("rst_done", o_frame_done, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_ovr", o_overrun, 1'b0);
    chk("rst_sat", o_sat, 1'b0);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    // Directed frame, ch5 factor doubled two cycles after the strobe
    do_frame(-1, 1'b0, 1, -1);
    chk("tp_identity", got_data[0], 32'h0000_1234);
    chk("tp_scale_off", got_data[3], 32'h0000_0002);
    chk("tp_snap_old", got_data[5], 32'd100);
`ifdef CALC_SAT_EN
    chk("tp_sat", got_data[9], 32'h7FFF_FFFF);
`else
    chk("tp_wrap", got_data[9], 32'hBFFF_7FFE);
`endif
    // Back-to-back: strobe on the first cycle after frame_done is accepted
    do_frame(-1, 1'b0, -1, -1);
    chk("tp_snap_new", got_data[5], 32'd200);

    // Strobe four cycles into a frame is ignored and flags overrun
    randomize_regs();
    @(negedge i_clk);
    do_frame(3, 1'b0, -1, -1);
    clear_overrun();

    // Strobe in the frame_done cycle, together with a clear: set wins
    randomize_regs();
    do_frame(CH + 3, 1'b1, -1, -1);
    clear_overrun();

    // Overrun then reset after channel 4 is output
    randomize_regs();
    do_frame(3, 1'b0, -1, 7);
    do_frame(-1, 1'b0, -1, -1);

    for (int n = 0; n < 5; n++) begin
      randomize_regs();
      repeat ($urandom_range(0, 3)) @(negedge i_clk);
      do_frame(-1, 1'b0, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
